// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies LOCK, then releases the system reset.
// Optional PLL_AUTO_RELOCK_EN: lock loss in RUN re-runs the PLL instead of faulting.
module pll_lock_seq #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] loss_count
);

   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [7:0]         loss_q, loss_d;
   logic               sync1_q, lock_s_q;
   logic               pll_reset_q, sys_rst_n_q, fault_q;

   // pll_lock comes from the PLL's own clock domain; only lock_s_q feeds decisions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_lock;
         lock_s_q <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == TO_LAST) begin
               retry_d = retry_q + 1'b1;
               state_d = (retry_q == RETRY_LAST) ? S_FAULT : S_RESET_PLL;
            end
         end
         S_STABLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end
         end
         S_RUN: begin
            if (!lock_s_q) begin
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`ifdef PLL_AUTO_RELOCK_EN
               state_d = S_RESET_PLL;
               retry_d = '0;
`else
               state_d = S_FAULT;
`endif
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_RESET_PLL;
         end
      endcase
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
   end

   // Outputs decode from the next state so they change on the same edge as state_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= 8'd0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
         sys_rst_n_q <= (state_d == S_RUN);
         fault_q     <= (state_d == S_FAULT);
      end
   end

   assign pll_reset  = pll_reset_q;
   assign sys_rst_n  = sys_rst_n_q;
   assign ready      = sys_rst_n_q;
   assign fault      = fault_q;
   assign state      = state_q;
   assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2.
// Expected edge numbers are hand-derived; PLL_AUTO_RELOCK_EN selects the relock expectations.
module tb_pll_lock_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       pll_reset;
   logic       sys_rst_n;
   logic       ready;
   logic       fault;
   logic [2:0] state;
   logic [7:0] loss_count;

   int checks = 0;
   int errors = 0;

   pll_lock_seq #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (32),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .pll_reset (pll_reset),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .fault     (fault),
      .state     (state),
      .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Each call passes exactly n rising edges and samples on the following falling edge
   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
      int n;
      n = 0;
      while (state !== exp && n < budget) begin
         adv(1);
         n++;
      end
      chk(tag, 32'(state), 32'(exp));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
      chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_fault"}, 32'(fault), 0);
      chk({tag, "_loss"}, 32'(loss_count), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      adv(2);
      chk_reset_vals("por");
      rst_n = 1'b1;

      // Lock high from reset: release after edge 13
      adv(3);
      chk("e3_pll_reset", 32'(pll_reset), 1);
      chk("e3_state", 32'(state), 0);
      adv(1);
      chk("e4_pll_reset", 32'(pll_reset), 0);
      chk("e4_state", 32'(state), 1);
      adv(1);
      chk("e5_state", 32'(state), 2);
      adv(7);
      chk("e12_sys_rst_n", 32'(sys_rst_n), 0);
      chk("e12_state", 32'(state), 2);
      adv(1);
      chk("e13_sys_rst_n", 32'(sys_rst_n), 1);
      chk("e13_ready", 32'(ready), 1);
      chk("e13_state", 32'(state), 3);

      // Lock loss in RUN: reaches the FSM on the third edge
      pll_lock = 1'b0;
      adv(2);
      chk("loss_e2_sys_rst_n", 32'(sys_rst_n), 1);
      adv(1);
      chk("loss_e3_sys_rst_n", 32'(sys_rst_n), 0);
      chk("loss_e3_pll_reset", 32'(pll_reset), 1);
      chk("loss_e3_count", 32'(loss_count), 1);
`ifdef PLL_AUTO_RELOCK_EN
      chk("loss_e3_state", 32'(state), 0);
      pll_lock = 1'b1;
      adv(3);
      chk("relock_rst3_pll_reset", 32'(pll_reset), 1);
      adv(1);
      chk("relock_rst4_pll_reset", 32'(pll_reset), 0);
      chk("relock_rst4_state", 32'(state), 1);
      adv(1);
      chk("relock_stable", 32'(state), 2);
      adv(8);
      chk("relock_run_state", 32'(state), 3);
      chk("relock_run_sys_rst_n", 32'(sys_rst_n), 1);

      // Second loss relocks, third loss with no lock exhausts retries
      pll_lock = 1'b0;
      adv(3);
      chk("loss2_count", 32'(loss_count), 2);
      pll_lock = 1'b1;
      wait_state("loss2_relock", 3'd3, 40);
      pll_lock = 1'b0;
      adv(3);
      chk("loss3_state", 32'(state), 0);
      wait_state("loss3_fault", 3'd4, 100);
      chk("loss3_count", 32'(loss_count), 3);
`else
      chk("loss_e3_state", 32'(state), 4);
      chk("loss_e3_fault", 32'(fault), 1);
      pll_lock = 1'b1;
      adv(20);
      chk("fault_hold_state", 32'(state), 4);
      chk("fault_hold_sys_rst_n", 32'(sys_rst_n), 0);
      chk("fault_hold_count", 32'(loss_count), 1);
`endif
      chk("fault_pre_rst_fault", 32'(fault), 1);

      // Reset asserted in FAULT clears immediately, without a clock edge
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      adv(2);
      rst_n = 1'b1;

      // Lock never asserts: two attempts then FAULT after edge 72
      adv(4);
      chk("nolock_e4_state", 32'(state), 1);
      chk("nolock_e4_pll_reset", 32'(pll_reset), 0);
      adv(32);
      chk("nolock_e36_state", 32'(state), 0);
      chk("nolock_e36_pll_reset", 32'(pll_reset), 1);
      adv(35);
      chk("nolock_e71_state", 32'(state), 1);
      adv(1);
      chk("nolock_e72_state", 32'(state), 4);
      chk("nolock_e72_fault", 32'(fault), 1);
      chk("nolock_e72_pll_reset", 32'(pll_reset), 1);
      chk("nolock_e72_sys_rst_n", 32'(sys_rst_n), 0);
      adv(50);
      chk("nolock_hold_fault", 32'(fault), 1);
      chk("nolock_hold_sys_rst_n", 32'(sys_rst_n), 0);

      // One-clock lock drop in STABLE at cnt=5 restarts qualification
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      adv(2);
      rst_n = 1'b1;
      adv(10);
      chk("glitch_e10_state", 32'(state), 2);
      pll_lock = 1'b0;
      adv(1);
      pll_lock = 1'b1;
      adv(2);
      chk("glitch_e13_state", 32'(state), 1);
      chk("glitch_e13_sys_rst_n", 32'(sys_rst_n), 0);
      adv(1);
      chk("glitch_e14_state", 32'(state), 2);
      adv(7);
      chk("glitch_e21_state", 32'(state), 2);
      chk("glitch_e21_sys_rst_n", 32'(sys_rst_n), 0);
      adv(1);
      chk("glitch_e22_state", 32'(state), 3);
      chk("glitch_e22_sys_rst_n", 32'(sys_rst_n), 1);

`ifdef PLL_AUTO_RELOCK_EN
      // 256 losses: the counter stops at 255
      for (int i = 0; i < 255; i++) begin
         pll_lock = 1'b0;
         adv(3);
         pll_lock = 1'b1;
         wait_state("sat_relock", 3'd3, 40);
      end
      chk("sat_255", 32'(loss_count), 255);
      pll_lock = 1'b0;
      adv(3);
      chk("sat_256_count", 32'(loss_count), 255);
      chk("sat_256_state", 32'(state), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
